stream_xbar_mcast: RTL and testbench
====================================

// Module: stream_xbar_mcast
// PURPOSE
// - Buffered NumInp x NumOut stream crossbar with optional multicast; successor to the unbuffered omega/xbar switches.
// - Each input names a destination mask; each output runs its own round-robin arbiter into a private output FIFO.
// - A multicast beat may reach its outputs in different cycles; per-input served masks track partial delivery.
// - Sits between stream masters (DMA/cores) and banked stream slaves. Per (input, output) pair order is preserved.
// PARAMETERS
// - NumInp     4   number of input ports, >=1
// - NumOut     4   number of output ports, >=1
// - DataWidth  32  payload width in bits
// - FifoDepth  2   entries per output FIFO, >=1
// - Multicast  1   1: sel_i may have any bit pattern; 0: sel_i must be one-hot (asserted)
// PORTS
// - clk        in   1                     clock
// - rst_n      in   1                     reset, asynchronous, active-high
// - flush_i    in   1                     synchronous clear of all state
// - data_i     in   NumInp*DataWidth      input payloads
// - sel_i      in   NumInp*NumOut         destination mask per input
// - valid_i    in   NumInp                input valid
// - ready_o    out  NumInp                input ready; beat retired on valid_i&ready_o
// - data_o     out  NumOut*DataWidth      output payloads (FIFO head)
// - idx_o      out  NumOut*IdxW           source input of head, IdxW=max(1,$clog2(NumInp))
// - valid_o    out  NumOut                output valid (FIFO non-empty)
// - ready_i    in   NumOut                output ready
// - fill_o     out  NumOut*$clog2(FifoDepth+1)  output FIFO occupancy
// BEHAVIOUR
// - Reset (rst_n=1): FIFOs empty, served masks 0, RR pointers 0; valid_o=0, fill_o=0, data_o/idx_o=0, ready_o=0.
// - Request: input i requests output j iff valid_i[i] & sel_i[i][j] & ~served[i][j].
// - Output j grants at most one requester per cycle, only if its FIFO is not full or pops this cycle.
// - Grant writes {data_i[i], i} into FIFO j; the entry is visible on valid_o[j] the next cycle (latency 1, no fall-through).
// - RR: pointer[j] = last granted index + 1 (mod NumInp); search starts at pointer. No grant -> pointer holds.
// - served[i] |= grant bits of this cycle. ready_o[i] = valid_i[i] & ((served[i]|grant_now[i]) covers sel_i[i]).
// - On ready_o[i] handshake: served[i] cleared to 0 in the same clock edge.
// - sel_i[i]==0 with valid_i[i]: ready_o[i]=1 same cycle, nothing enqueued.
// - Inputs: data_i/sel_i stable while valid_i & ~ready_o (asserted); valid_i must not drop before ready_o (asserted).
// - Multicast=0: $onehot0(sel_i[i]) asserted whenever valid_i[i].
// - Full FIFO: no grant to that output; other outputs of a multicast beat still proceed (partial delivery).
// - Simultaneous push and pop on full FIFO allowed; fill unchanged. Pop on empty impossible (valid_o=0).
// - Ordering: beats from input i to output j leave in issue order; no ordering across inputs.
// - flush_i: next edge empties FIFOs, clears served masks and pointers; ready_o=0 and no grants while flush_i=1.
// - Reset mid-operation: all in-flight and partially delivered beats are discarded; no output handshake until refilled.
// STRUCTURE
// - stream_xbar_mcast_pkg: idx/fill width functions, one-hot/mask helpers.
// - Sub-module stream_xbar_mcast_out (per output, generated NumOut times): RR arbiter + pointer + FIFO + fill counter.
// - Top: request matrix, served-mask registers, ready_o reduction, assertions.
// TESTING
// - Unicast 4x4, Depth=2, sinks ready: input0 sends 0xA5 to out2 -> valid_o[2] next cycle, data_o=0xA5, idx_o=0.
// - Contention: inputs 0..3 all to out1 every cycle, ready_i=1 -> grant order 0,1,2,3,0.. and one output beat/cycle.
// - Multicast sel=4'b1011 from input2, ready_i[3]=0 with FIFO3 full -> out0/out1 get beat; ready_o[2] only after out3 drains; no duplicates.
// - Backpressure: ready_i[0]=0 for 10 cycles, input1 streams 5 beats to out0 -> fill_o[0]=2, ready_o[1] low; drain -> order 1..5 preserved.
// - sel_i=0 with valid -> ready_o=1 same cycle, no valid_o rise anywhere.
// - flush_i pulse with FIFOs full and partial multicast -> next cycle valid_o=0, fill_o=0, served masks 0; then random traffic to scoreboard.

Source files
------------

// File: rtl/stream_xbar_mcast_pkg.sv
// Shared width helpers and mask utilities for the multicast stream crossbar.
package stream_xbar_mcast_pkg;

   // Widest destination mask the coverage helper handles.
   localparam int unsigned MaskW = 32;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned fill_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // True when every bit requested in want is present in have.
   function automatic logic mask_covers(input logic [MaskW-1:0] have,
                                        input logic [MaskW-1:0] want);
      return (have & want) == want;
   endfunction

endpackage

// File: rtl/stream_xbar_mcast_out.sv
// One crossbar output: round-robin arbiter over all inputs feeding a private FIFO.
module stream_xbar_mcast_out
   import stream_xbar_mcast_pkg::*;
#(
   parameter int unsigned NumInp    = 4,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned FifoDepth = 2,
   localparam int unsigned IdxW     = idx_width(NumInp),
   localparam int unsigned FillW    = fill_width(FifoDepth)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_i,
   input  logic [NumInp-1:0]           req_i,
   input  logic [NumInp*DataWidth-1:0] data_i,
   output logic [NumInp-1:0]           gnt_c_o,
   output logic [DataWidth-1:0]        data_o,
   output logic [IdxW-1:0]             idx_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [FillW-1:0]            fill_o
);
   localparam int unsigned PtrW = idx_width(FifoDepth);

   logic [DataWidth-1:0] mem_q [FifoDepth];
   logic [IdxW-1:0]      src_q [FifoDepth];
   logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [FillW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]      rr_q, rr_d;
   logic [IdxW-1:0]      win;
   logic                 found, full, push, pop;
   int unsigned          cand;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Round-robin search starting at the pointer.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = 0;
      for (int unsigned k = 0; k < NumInp; k++) begin
         cand = (32'(rr_q) + k) % NumInp;
         if (!found && req_i[IdxW'(cand)]) begin
            found = 1'b1;
            win   = IdxW'(cand);
         end
      end
   end

   assign valid_o = (cnt_q != '0);
   assign full    = (cnt_q == FillW'(FifoDepth));
   assign pop     = valid_o & ready_i;
   assign push    = found & ~flush_i & (~full | pop);
   assign fill_o  = cnt_q;
   assign data_o  = valid_o ? mem_q[rptr_q] : '0;
   assign idx_o   = valid_o ? src_q[rptr_q] : '0;

   always_comb begin
      gnt_c_o = '0;
      for (int unsigned i = 0; i < NumInp; i++) begin
         gnt_c_o[i] = push && (win == IdxW'(i));
      end
   end

   always_comb begin
      rr_d   = rr_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         rr_d   = '0;
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) begin
            rr_d   = (win == IdxW'(NumInp - 1)) ? '0 : win + IdxW'(1);
            wptr_d = ptr_inc(wptr_q);
         end
         if (pop) rptr_d = ptr_inc(rptr_q);
         if (push && !pop)      cnt_d = cnt_q + FillW'(1);
         else if (!push && pop) cnt_d = cnt_q - FillW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rr_q   <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         rr_q   <= rr_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Payload storage needs no reset: heads are masked until valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= data_i[win*DataWidth +: DataWidth];
         src_q[wptr_q] <= win;
      end
   end

endmodule

// File: rtl/stream_xbar_mcast.sv
// Buffered NumInp x NumOut stream crossbar with multicast and per-input partial-delivery tracking.
module stream_xbar_mcast
   import stream_xbar_mcast_pkg::*;
#(
   parameter int unsigned NumInp    = 4,
   parameter int unsigned NumOut    = 4,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned FifoDepth = 2,
   parameter bit          Multicast = 1'b1,
   localparam int unsigned IdxW     = idx_width(NumInp),
   localparam int unsigned FillW    = fill_width(FifoDepth)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_i,
   input  logic [NumInp*DataWidth-1:0] data_i,
   input  logic [NumInp*NumOut-1:0]    sel_i,
   input  logic [NumInp-1:0]           valid_i,
   output logic [NumInp-1:0]           ready_o,
   output logic [NumOut*DataWidth-1:0] data_o,
   output logic [NumOut*IdxW-1:0]      idx_o,
   output logic [NumOut-1:0]           valid_o,
   input  logic [NumOut-1:0]           ready_i,
   output logic [NumOut*FillW-1:0]     fill_o
);
   logic [NumOut-1:0] sel      [NumInp];
   logic [NumOut-1:0] served_q [NumInp];
   logic [NumOut-1:0] served_d [NumInp];
   logic [NumOut-1:0] gnt      [NumInp];
   logic [NumInp-1:0] req_col  [NumOut];
   logic [NumInp-1:0] gnt_col  [NumOut];
   logic              active;

   assign active = ~rst_n & ~flush_i;

   // Request matrix: outputs already reached by this beat stop requesting.
   always_comb begin
      sel     = '{default: '0};
      req_col = '{default: '0};
      for (int unsigned i = 0; i < NumInp; i++) begin
         for (int unsigned j = 0; j < NumOut; j++) begin
            sel[i][j]     = sel_i[i*NumOut + j];
            req_col[j][i] = active & valid_i[i] & sel[i][j] & ~served_q[i][j];
         end
      end
   end

   always_comb begin
      gnt = '{default: '0};
      for (int unsigned i = 0; i < NumInp; i++) begin
         for (int unsigned j = 0; j < NumOut; j++) begin
            gnt[i][j] = gnt_col[j][i];
         end
      end
   end

   // A beat retires once this cycle's grants complete its destination set.
   always_comb begin
      ready_o  = '0;
      served_d = '{default: '0};
      for (int unsigned i = 0; i < NumInp; i++) begin
         ready_o[i]  = active & valid_i[i] &
                       mask_covers(MaskW'(served_q[i] | gnt[i]), MaskW'(sel[i]));
         served_d[i] = (flush_i | ready_o[i]) ? '0 : (served_q[i] | gnt[i]);
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) served_q <= '{default: '0};
      else       served_q <= served_d;
   end

   for (genvar j = 0; j < NumOut; j++) begin : g_out
      stream_xbar_mcast_out #(
         .NumInp    (NumInp),
         .DataWidth (DataWidth),
         .FifoDepth (FifoDepth)
      ) u_out (
         .clk     (clk),
         .rst_n   (rst_n),
         .flush_i (flush_i),
         .req_i   (req_col[j]),
         .data_i  (data_i),
         .gnt_c_o (gnt_col[j]),
         .data_o  (data_o[j*DataWidth +: DataWidth]),
         .idx_o   (idx_o[j*IdxW +: IdxW]),
         .valid_o (valid_o[j]),
         .ready_i (ready_i[j]),
         .fill_o  (fill_o[j*FillW +: FillW])
      );
   end

   for (genvar i = 0; i < NumInp; i++) begin : g_chk
      a_hold : assert property (@(posedge clk) disable iff (rst_n)
         valid_i[i] && !ready_o[i] && !flush_i |=> valid_i[i] &&
         $stable(sel_i[i*NumOut +: NumOut]) && $stable(data_i[i*DataWidth +: DataWidth]));
      if (!Multicast) begin : g_uc
         a_onehot : assert property (@(posedge clk) disable iff (rst_n)
            valid_i[i] |-> $onehot0(sel_i[i*NumOut +: NumOut]));
      end
   end

endmodule

// File: tb/tb_stream_xbar_mcast.sv
// Directed and scoreboarded checks for the 4x4 multicast stream crossbar.
module tb_stream_xbar_mcast;
   logic         clk = 1'b0;
   logic         rst_n, flush_i;
   logic [127:0] data_i;
   logic [15:0]  sel_i;
   logic [3:0]   valid_i, ready_o, valid_o, ready_i;
   logic [127:0] data_o;
   logic [7:0]   idx_o, fill_o;
   logic [31:0]  din [4];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] sel;
      logic [3:0]  rdy;
      logic [3:0]  exp_ready;
      logic [3:0]  exp_valid;
      logic [7:0]  exp_fill;
      logic [7:0]  exp_idx;
   } vec_t;

   vec_t vecs [10];
   int unsigned exp_q [4][4][$];

   stream_xbar_mcast dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .data_i  (data_i),
      .sel_i   (sel_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .idx_o   (idx_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .fill_o  (fill_o)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) data_i[i*32 +: 32] = din[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  e;
      logic [31:0] d;
      logic [1:0]  src;
      logic        pend [4];
      int unsigned seqn [4];
      int          b, r, remaining, npend;
      logic        hs;

      vecs[0] = '{4'h0, 16'h0000, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00};
      vecs[1] = '{4'h1, 16'h0004, 4'hF, 4'h1, 4'h4, 8'h10, 8'h00};
      vecs[2] = '{4'h0, 16'h0000, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00};
      vecs[3] = '{4'h8, 16'h0000, 4'hF, 4'h8, 4'h0, 8'h00, 8'h00};
      vecs[4] = '{4'h2, 16'h0010, 4'hE, 4'h2, 4'h1, 8'h01, 8'h01};
      vecs[5] = '{4'h2, 16'h0010, 4'hE, 4'h2, 4'h1, 8'h02, 8'h01};
      vecs[6] = '{4'h2, 16'h0010, 4'hE, 4'h0, 4'h1, 8'h02, 8'h01};
      vecs[7] = '{4'h2, 16'h0010, 4'hF, 4'h2, 4'h1, 8'h02, 8'h01};
      vecs[8] = '{4'h0, 16'h0000, 4'hF, 4'h0, 4'h1, 8'h01, 8'h01};
      vecs[9] = '{4'h0, 16'h0000, 4'hF, 4'h0, 4'h0, 8'h00, 8'h00};

      for (int i = 0; i < 4; i++) din[i] = 32'hA5 + 32'(i) * 16;
      rst_n   = 1'b1;
      flush_i = 1'b0;
      valid_i = 4'hF;
      sel_i   = 16'hFFFF;
      ready_i = 4'hF;
      tick();
      tick();
      chk("rst_ready", 32'(ready_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_fill", 32'(fill_o), 0);
      chk("rst_idx", 32'(idx_o), 0);
      chk("rst_data", data_o[31:0] | data_o[63:32] | data_o[95:64] | data_o[127:96], 0);
      valid_i = 4'h0;
      sel_i   = 16'h0;
      rst_n   = 1'b0;
      tick();

      // Table: unicast, zero destination mask, backpressure on a depth-2 FIFO.
      for (int v = 0; v < 10; v++) begin
         valid_i = vecs[v].valid;
         sel_i   = vecs[v].sel;
         ready_i = vecs[v].rdy;
         #1;
         chk($sformatf("vec%0d_ready", v), 32'(ready_o), 32'(vecs[v].exp_ready));
         tick();
         chk($sformatf("vec%0d_valid", v), 32'(valid_o), 32'(vecs[v].exp_valid));
         chk($sformatf("vec%0d_fill", v), 32'(fill_o), 32'(vecs[v].exp_fill));
         chk($sformatf("vec%0d_idx", v), 32'(idx_o), 32'(vecs[v].exp_idx));
         for (int j = 0; j < 4; j++) begin
            if (vecs[v].exp_valid[j]) begin
               src = vecs[v].exp_idx[j*2 +: 2];
               chk($sformatf("vec%0d_data%0d", v, j), data_o[j*32 +: 32], 32'hA5 + 32'(src) * 16);
            end
         end
      end

      // Contention: all inputs to out1, round-robin from pointer 0.
      valid_i = 4'hF;
      sel_i   = 16'h2222;
      ready_i = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         e = 4'b0001 << (k % 4);
         chk($sformatf("rr%0d_ready", k), 32'(ready_o), 32'(e));
         tick();
         chk($sformatf("rr%0d_valid1", k), 32'(valid_o), 32'h2);
         chk($sformatf("rr%0d_idx1", k), 32'(idx_o[3:2]), 32'(k % 4));
         chk($sformatf("rr%0d_fill1", k), 32'(fill_o[3:2]), 1);
      end
      flush_i = 1'b1;
      #1;
      chk("rr_flush_ready", 32'(ready_o), 0);
      tick();
      flush_i = 1'b0;
      valid_i = 4'h0;
      sel_i   = 16'h0;
      chk("rr_flush_valid", 32'(valid_o), 0);
      chk("rr_flush_fill", 32'(fill_o), 0);

      // Multicast 1011 from input2 while out3 is full and stalled.
      ready_i = 4'b0111;
      valid_i = 4'b0001;
      sel_i   = 16'h0008;
      tick();
      tick();
      chk("mc_prefill", 32'(fill_o), 32'h80);
      valid_i = 4'b0100;
      sel_i   = 16'h0B00;
      #1;
      chk("mc_a_ready", 32'(ready_o), 0);
      tick();
      chk("mc_a_valid", 32'(valid_o), 32'hB);
      chk("mc_a_fill", 32'(fill_o), 32'h85);
      chk("mc_a_idx", 32'(idx_o), 32'h0A);
      #1;
      chk("mc_b_ready", 32'(ready_o), 0);
      tick();
      chk("mc_b_valid", 32'(valid_o), 32'h8);
      chk("mc_b_fill", 32'(fill_o), 32'h80);
      ready_i = 4'hF;
      #1;
      chk("mc_c_ready", 32'(ready_o), 32'h4);
      tick();
      chk("mc_c_valid", 32'(valid_o), 32'h8);
      chk("mc_c_fill", 32'(fill_o), 32'h80);
      chk("mc_c_idx3", 32'(idx_o[7:6]), 0);
      valid_i = 4'h0;
      sel_i   = 16'h0;
      tick();
      chk("mc_d_idx3", 32'(idx_o[7:6]), 2);
      chk("mc_d_fill", 32'(fill_o), 32'h40);
      tick();
      chk("mc_e_valid", 32'(valid_o), 0);

      // Backpressure: out0 stalled 10 cycles, input1 streams 5 numbered beats.
      ready_i = 4'b1110;
      sel_i   = 16'h0010;
      b = 1;
      for (int c = 0; c < 10; c++) begin
         valid_i = {2'b00, (b <= 5), 1'b0};
         din[1]  = 32'(b);
         #1;
         hs = valid_i[1] & ready_o[1];
         tick();
         if (hs) b++;
      end
      valid_i = {2'b00, (b <= 5), 1'b0};
      din[1]  = 32'(b);
      #1;
      chk("bp_fill0", 32'(fill_o[1:0]), 2);
      chk("bp_ready1", 32'(ready_o[1]), 0);
      ready_i = 4'hF;
      r = 0;
      for (int c = 0; c < 30 && !(r == 5 && b > 5); c++) begin
         valid_i = {2'b00, (b <= 5), 1'b0};
         din[1]  = 32'(b);
         #1;
         if (valid_o[0]) begin
            chk("bp_order", data_o[31:0], 32'(r + 1));
            chk("bp_src", 32'(idx_o[1:0]), 1);
            r++;
         end
         hs = valid_i[1] & ready_o[1];
         tick();
         if (hs) b++;
      end
      chk("bp_count", 32'(r), 5);
      valid_i = 4'h0;
      sel_i   = 16'h0;

      // Flush with out3 full and a partially delivered multicast beat.
      ready_i = 4'h0;
      valid_i = 4'b0001;
      sel_i   = 16'h0008;
      tick();
      tick();
      valid_i = 4'b0100;
      sel_i   = 16'h0B00;
      tick();
      flush_i = 1'b1;
      #1;
      chk("fl_ready", 32'(ready_o), 0);
      tick();
      flush_i = 1'b0;
      chk("fl_valid", 32'(valid_o), 0);
      chk("fl_fill", 32'(fill_o), 0);
      ready_i = 4'hF;
      #1;
      chk("fl_reissue_ready", 32'(ready_o), 32'h4);
      tick();
      chk("fl_reissue_valid", 32'(valid_o), 32'hB);
      chk("fl_reissue_fill", 32'(fill_o), 32'h45);
      valid_i = 4'h0;
      sel_i   = 16'h0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;

      // Random traffic against a per-(input, output) order scoreboard.
      for (int i = 0; i < 4; i++) begin
         pend[i] = 1'b0;
         seqn[i] = 0;
      end
      for (int cyc = 0; cyc < 700; cyc++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && cyc < 400 && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1;
               seqn[i]++;
               din[i] = {8'(i), 24'(seqn[i])};
               sel_i[i*4 +: 4] = 4'($urandom_range(0, 15));
               for (int j = 0; j < 4; j++)
                  if (sel_i[i*4 + j]) exp_q[i][j].push_back(seqn[i]);
            end
            valid_i[i] = pend[i];
         end
         ready_i = (cyc < 400) ? 4'($urandom_range(0, 15)) : 4'hF;
         #1;
         for (int j = 0; j < 4; j++) begin
            if (valid_o[j] && ready_i[j]) begin
               d   = data_o[j*32 +: 32];
               src = idx_o[j*2 +: 2];
               chk("sb_src", 32'(src), 32'(d[31:24]));
               if (exp_q[src][j].size() == 0) begin
                  chk("sb_extra", 1, 0);
               end else begin
                  chk("sb_order", 32'(d[23:0]), 32'(24'(exp_q[src][j].pop_front())));
               end
            end
         end
         for (int i = 0; i < 4; i++)
            if (pend[i] && ready_o[i]) pend[i] = 1'b0;
         tick();
      end
      remaining = 0;
      npend     = 0;
      for (int i = 0; i < 4; i++) begin
         if (pend[i]) npend++;
         for (int j = 0; j < 4; j++) remaining += exp_q[i][j].size();
      end
      chk("sb_undelivered", 32'(remaining), 0);
      chk("sb_pending", 32'(npend), 0);
      chk("sb_idle_valid", 32'(valid_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
